// File: rtl/efpga_arb_pkg.sv
// Shared types and constants for the eFPGA request arbiter: FSM states,
// operator codes and the delay value that means "wait for the wrapper's done".
package efpga_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] OP_A  = 2'b00;
    localparam logic [1:0] OP_B  = 2'b01;
    localparam logic [1:0] OP_C  = 2'b10;
    localparam logic [1:0] OP_WR = 2'b11;

    localparam logic [3:0] DELAY_EXT = 4'hF;

endpackage

// File: rtl/efpga_rr_pick.sv
// Combinational round-robin picker: the first active request after last_grant_i,
// wrapping modulo NUM_REQ, wins.
module efpga_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_grant_i,
    output logic [IDXW-1:0]    winner_o,
    output logic               any_o
);

    logic [IDXW-1:0] cand;

    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDXW'((int'(last_grant_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                winner_o = cand;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/efpga_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one eFPGA wrapper between NUM_REQ requesters.
// Optional watchdog with stale-wrapper lockout: define EFPGA_ARB_TIMEOUT_EN.
module efpga_req_arbiter
    import efpga_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [2*NUM_REQ-1:0]       req_operator_i,
    input  logic [4*NUM_REQ-1:0]       req_delay_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [31:0]                rsp_result_o,
    output logic                       rsp_error_o,
    output logic                       efpga_en_o,
    output logic [1:0]                 efpga_operator_o,
    output logic [3:0]                 efpga_delay_o,
    input  logic                       efpga_ready_i,
    input  logic [31:0]                efpga_result_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_e         state_q;
    logic [IDXW-1:0]    owner_q;
    logic [IDXW-1:0]    last_grant_q;
    logic [1:0]         op_q;
    logic [3:0]         delay_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               en_q;
    logic [31:0]        result_q;

    logic [IDXW-1:0]    pick_idx_d;
    logic               pick_any_d;
    logic [1:0]         pick_op_d;
    logic [3:0]         pick_delay_d;
    logic               grant_blocked;

    efpga_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_idx_d),
        .any_o        (pick_any_d)
    );

    always_comb begin
        pick_op_d    = '0;
        pick_delay_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_d == IDXW'(i)) begin
                pick_op_d    = req_operator_i[2*i +: 2];
                pick_delay_d = req_delay_i[4*i +: 4];
            end
        end
    end

`ifdef EFPGA_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       stale_q;
    logic       error_q;

    // A ready pulse seen in IDLE releases the lockout in the same cycle.
    assign grant_blocked = stale_q && !efpga_ready_i;
    assign rsp_error_o   = error_q;
`else
    assign grant_blocked = 1'b0;
    assign rsp_error_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            op_q         <= '0;
            delay_q      <= '0;
            ready_q      <= '0;
            rsp_valid_q  <= '0;
            en_q         <= 1'b0;
            result_q     <= '0;
`ifdef EFPGA_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            stale_q      <= 1'b0;
            error_q      <= 1'b0;
`endif
        end else begin
            ready_q     <= '0;
            rsp_valid_q <= '0;
            en_q        <= 1'b0;
`ifdef EFPGA_ARB_TIMEOUT_EN
            if (efpga_ready_i) begin
                stale_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pick_any_d && !grant_blocked) begin
                        state_q <= ISSUE;
                        owner_q <= pick_idx_d;
                        op_q    <= pick_op_d;
                        delay_q <= pick_delay_d;
                        ready_q <= ONE << pick_idx_d;
                        en_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef EFPGA_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    // Ready takes priority over a coinciding watchdog expiry.
                    if (efpga_ready_i) begin
                        state_q     <= RESP;
                        result_q    <= efpga_result_i;
                        rsp_valid_q <= ONE << owner_q;
`ifdef EFPGA_ARB_TIMEOUT_EN
                        error_q     <= 1'b0;
`endif
                    end
`ifdef EFPGA_ARB_TIMEOUT_EN
                    else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= RESP;
                        result_q    <= '0;
                        rsp_valid_q <= ONE << owner_q;
                        error_q     <= 1'b1;
                        stale_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                RESP: begin
                    state_q      <= IDLE;
                    last_grant_q <= owner_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = result_q;
    assign efpga_en_o       = en_q;
    assign efpga_operator_o = op_q;
    assign efpga_delay_o    = delay_q;
    assign busy_o           = (state_q != IDLE);
    assign owner_o          = owner_q;

endmodule

// File: tb/tb_efpga_req_arbiter.sv
// Self-checking bench for efpga_req_arbiter: directed scenarios plus a randomized
// phase, all checked cycle by cycle against a transaction-level reference model.
module tb_efpga_req_arbiter;
    import efpga_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid_i = '0;
    logic [2*N-1:0]   req_operator_i = '0;
    logic [4*N-1:0]   req_delay_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0]     rsp_valid_o;
    logic [31:0]      rsp_result_o;
    logic             rsp_error_o;
    logic             efpga_en_o;
    logic [1:0]       efpga_operator_o;
    logic [3:0]       efpga_delay_o;
    logic             efpga_ready_i = 1'b0;
    logic [31:0]      efpga_result_i = '0;
    logic             busy_o;
    logic [$clog2(N)-1:0] owner_o;

    always #5 clk = ~clk;

    efpga_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_operator_i   (req_operator_i),
        .req_delay_i      (req_delay_i),
        .req_ready_o      (req_ready_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_result_o     (rsp_result_o),
        .rsp_error_o      (rsp_error_o),
        .efpga_en_o       (efpga_en_o),
        .efpga_operator_o (efpga_operator_o),
        .efpga_delay_o    (efpga_delay_o),
        .efpga_ready_i    (efpga_ready_i),
        .efpga_result_i   (efpga_result_i),
        .busy_o           (busy_o),
        .owner_o          (owner_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Wrapper stub: ready pulses d+2 cycles after the en pulse (or a forced latency).
    int          stub_cnt = 0;
    int          stub_lat_override = 0;
    int          stub_ext_lat = 9;
    bit          stub_never = 1'b0;
    bit          stub_fixed_en = 1'b0;
    logic [31:0] stub_fixed = '0;
    logic [31:0] stub_issued = '0;

    initial begin : wrapper_stub
        forever begin
            @(posedge clk);
            #1;
            efpga_ready_i = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    efpga_ready_i  = 1'b1;
                    efpga_result_i = stub_issued;
                end
            end
            if (efpga_en_o && !stub_never) begin
                stub_issued = stub_fixed_en ? stub_fixed : $urandom;
                if (stub_lat_override > 0)        stub_cnt = stub_lat_override;
                else if (efpga_delay_o == DELAY_EXT) stub_cnt = stub_ext_lat;
                else                              stub_cnt = int'(efpga_delay_o) + 2;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: tracks when the arbiter is free, who wins next and when
    // the response is due, at the level of whole transactions.
    bit          model_on = 1'b0;
    int          idle_from = 0;
    int          grant_cyc = -100;
    int          rsp_cyc = -100;
    int          m_last = N - 1;
    int          m_owner = 0;
    logic [1:0]  m_op = '0;
    logic [3:0]  m_dly = '0;
    logic [31:0] m_result = '0;
    logic [N-1:0] prev_valid = '0;
    logic [1:0]  prev_op [N];
    logic [3:0]  prev_dly [N];
    logic [N-1:0] exp_ready = '0;
    int          rand_grants = 0;

    function automatic int rrPick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int modelLatency(input logic [3:0] d);
        if (stub_lat_override > 0) return stub_lat_override;
        if (d == DELAY_EXT)        return stub_ext_lat;
        return int'(d) + 2;
    endfunction

    task automatic modelReset();
        idle_from = cyc;
        grant_cyc = -100;
        rsp_cyc   = -100;
        m_last    = N - 1;
        m_owner   = 0;
        m_op      = '0;
        m_dly     = '0;
        m_result  = '0;
        model_on  = 1'b1;
    endtask

    task automatic checkOutput();
        int w;
        logic [N-1:0] exp_rsp;
        exp_ready = '0;
        exp_rsp   = '0;
        if (!model_on) return;
        if ((cyc - 1 >= idle_from) && (prev_valid != '0)) begin
            w            = rrPick(prev_valid, m_last);
            exp_ready[w] = 1'b1;
            m_owner      = w;
            m_last       = w;
            m_op         = prev_op[w];
            m_dly        = prev_dly[w];
            grant_cyc    = cyc;
            rsp_cyc      = cyc + modelLatency(m_dly) + 1;
            idle_from    = rsp_cyc + 1;
        end
        if (cyc == rsp_cyc) begin
            exp_rsp[m_owner] = 1'b1;
            m_result         = stub_issued;
        end
        chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
        chk("efpga_en", 32'(efpga_en_o), 32'(exp_ready != '0));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp));
        chk("busy", 32'(busy_o), 32'(cyc >= grant_cyc && cyc <= rsp_cyc));
        chk("owner", 32'(owner_o), 32'(m_owner));
        chk("efpga_operator", 32'(efpga_operator_o), 32'(m_op));
        chk("efpga_delay", 32'(efpga_delay_o), 32'(m_dly));
        chk("rsp_result", rsp_result_o, m_result);
        chk("rsp_error", 32'(rsp_error_o), 32'd0);
    endtask

    task automatic step();
        prev_valid = req_valid_i;
        for (int i = 0; i < N; i++) begin
            prev_op[i]  = req_operator_i[2*i +: 2];
            prev_dly[i] = req_delay_i[4*i +: 4];
        end
        @(posedge clk);
        #2;
        cyc++;
        checkOutput();
    endtask

    task automatic setReq(input int i, input logic v, input logic [1:0] op, input logic [3:0] d);
        req_valid_i[i]          = v;
        req_operator_i[2*i +: 2] = op;
        req_delay_i[4*i +: 4]    = d;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                req_valid_i[i] = 1'b0;
            end else if (!req_valid_i[i] && $urandom_range(0, 3) == 0) begin
                setReq(i, 1'b1, 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 7) ? DELAY_EXT : 4'($urandom_range(0, 6)));
            end
        end
    endtask

    task automatic chkAllZero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy_o), 32'd0);
        chk({pfx, "_owner"}, 32'(owner_o), 32'd0);
        chk({pfx, "_req_ready"}, 32'(req_ready_o), 32'd0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({pfx, "_rsp_result"}, rsp_result_o, 32'd0);
        chk({pfx, "_rsp_error"}, 32'(rsp_error_o), 32'd0);
        chk({pfx, "_efpga_en"}, 32'(efpga_en_o), 32'd0);
        chk({pfx, "_efpga_op"}, 32'(efpga_operator_o), 32'd0);
        chk({pfx, "_efpga_dly"}, 32'(efpga_delay_o), 32'd0);
    endtask

    initial begin : main
        int order[$];
        int exp_order[5];
        bit got;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chkAllZero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        modelReset();

        // Single request from requester 2
        stub_fixed_en = 1'b1;
        stub_fixed    = 32'hCAFE0001;
        setReq(2, 1'b1, OP_B, 4'd3);
        step();
        chk("t1_ready", 32'(req_ready_o), 32'b0100);
        chk("t1_en", 32'(efpga_en_o), 32'd1);
        chk("t1_op", 32'(efpga_operator_o), 32'(OP_B));
        req_valid_i[2] = 1'b0;
        repeat (5) step();
        step();
        chk("t1_rsp_valid", 32'(rsp_valid_o), 32'b0100);
        chk("t1_result", rsp_result_o, 32'hCAFE0001);
        repeat (2) step();

        // Spurious ready while idle
        efpga_ready_i  = 1'b1;
        efpga_result_i = 32'hDEADBEEF;
        step();
        chk("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("spur_busy", 32'(busy_o), 32'd0);
        chk("spur_result_held", rsp_result_o, 32'hCAFE0001);
        step();
        stub_fixed_en = 1'b0;

        // Operand stability over a long WAIT
        stub_lat_override = 20;
        setReq(1, 1'b1, OP_WR, 4'd5);
        step();
        chk("t3_ready", 32'(req_ready_o), 32'b0010);
        setReq(1, 1'b0, OP_A, 4'd9);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_op_stable", 32'(efpga_operator_o), 32'(OP_WR));
            chk("t3_dly_stable", 32'(efpga_delay_o), 32'd5);
        end
        step();
        chk("t3_rsp_valid", 32'(rsp_valid_o), 32'b0010);
        stub_lat_override = 0;
        repeat (2) step();

        // Asynchronous reset in WAIT, then all four requesters held continuously
        setReq(3, 1'b1, OP_C, 4'd6);
        step();
        req_valid_i[3] = 1'b0;
        repeat (3) step();
        chk("t4_in_wait_busy", 32'(busy_o), 32'd1);
        #1 rst_n = 1'b0;
        model_on = 1'b0;
        stub_cnt = 0;
        #1;
        chkAllZero("async_rst");
        for (int i = 0; i < N; i++) setReq(i, 1'b1, 2'(i), 4'(i));
        repeat (2) @(posedge clk);
        #2;
        chk("async_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        rst_n = 1'b1;
        modelReset();
        for (int t = 0; t < 200 && order.size() < 5; t++) begin
            step();
            for (int i = 0; i < N; i++) if (req_ready_o[i]) order.push_back(i);
        end
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFFFFFF,
                32'(exp_order[i]));
        req_valid_i = '0;
        repeat (15) step();

        // Randomized traffic
        for (int t = 0; t < 500; t++) begin
            applyStimulus();
            step();
            if (exp_ready != '0) rand_grants++;
        end
        chk("rand_grants_seen", 32'(rand_grants > 20), 32'd1);
        req_valid_i = '0;
        repeat (30) step();

`ifdef EFPGA_ARB_TIMEOUT_EN
        // Watchdog expiry and stale lockout
        model_on   = 1'b0;
        stub_never = 1'b1;
        setReq(3, 1'b1, OP_A, DELAY_EXT);
        got = 1'b0;
        for (int t = 0; t < 5 && !got; t++) begin
            step();
            if (req_ready_o != '0) got = 1'b1;
        end
        chk("to_grant_seen", 32'(got), 32'd1);
        req_valid_i[3] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            step();
            if (rsp_valid_o != '0) got = 1'b1;
        end
        chk("to_rsp_seen", 32'(got), 32'd1);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'b1000);
        chk("to_error", 32'(rsp_error_o), 32'd1);
        chk("to_result", rsp_result_o, 32'd0);
        setReq(0, 1'b1, OP_C, 4'd2);
        for (int t = 0; t < 8; t++) begin
            step();
            chk("stale_no_grant", 32'(req_ready_o), 32'd0);
        end
        stub_never     = 1'b0;
        stub_fixed_en  = 1'b1;
        stub_fixed     = 32'h0000BEEF;
        efpga_ready_i  = 1'b1;
        step();
        chk("stale_release_grant", 32'(req_ready_o), 32'b0001);
        req_valid_i[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (rsp_valid_o != '0) got = 1'b1;
        end
        chk("post_stale_rsp_seen", 32'(got), 32'd1);
        chk("post_stale_error", 32'(rsp_error_o), 32'd0);
        chk("post_stale_result", rsp_result_o, 32'h0000BEEF);
        repeat (3) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
